// File: rtl/step_sequencer.sv
// Phase sequencer for the datapath registers: walks FETCH -> LOAD -> STORE -> CAPTURE,
// stalls on memory handshakes, supports halt/resume, and counts retired instructions.
module step_sequencer #(
   parameter logic [1:0]  CAPTURE     = 2'h0,
   parameter logic [1:0]  FETCH       = 2'h1,
   parameter logic [1:0]  LOAD        = 2'h2,
   parameter logic [1:0]  STORE       = 2'h3,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   load_needed,
   input  logic                   store_needed,
   input  logic                   read_ready,
   input  logic                   write_ready,
   input  logic                   halt_request,
   input  logic                   resume,
   output logic [1:0]             step,
   output logic                   read_request,
   output logic                   write_request,
   output logic                   halted,
   output logic [COUNT_WIDTH-1:0] retired
);

   typedef enum logic {StRun, StHalted} ctrl_e;

   ctrl_e                  ctrl_q, ctrl_d;
   logic [1:0]             step_q, step_d;
   logic                   store_q, store_d;
   logic [COUNT_WIDTH-1:0] retired_q, retired_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         ctrl_q    <= StRun;
         step_q    <= FETCH;
         store_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         step_q    <= step_d;
         store_q   <= store_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      step_d    = step_q;
      store_d   = store_q;
      retired_d = retired_q;
      if (ctrl_q == StHalted) begin
         // halt_request is ignored here, so resume always wins
         if (resume) begin
            ctrl_d = StRun;
            step_d = FETCH;
         end
      end else begin
         unique case (step_q)
            FETCH: begin
               if (read_ready) begin
                  // store decision is frozen here for the rest of the instruction
                  store_d = store_needed;
                  if (load_needed) begin
                     step_d = LOAD;
                  end else if (store_needed) begin
                     step_d = STORE;
                  end else begin
                     step_d = CAPTURE;
                  end
               end
            end
            LOAD: begin
               if (read_ready) begin
                  step_d = store_q ? STORE : CAPTURE;
               end
            end
            STORE: begin
               if (write_ready) begin
                  step_d = CAPTURE;
               end
            end
            CAPTURE: begin
               retired_d = retired_q + 1'b1;
               step_d    = FETCH;
               if (halt_request) begin
                  ctrl_d = StHalted;
               end
            end
            default: step_d = FETCH;
         endcase
      end
   end

   assign step          = step_q;
   assign read_request  = (ctrl_q == StRun) && ((step_q == FETCH) || (step_q == LOAD));
   assign write_request = (ctrl_q == StRun) && (step_q == STORE);
   assign halted        = (ctrl_q == StHalted);
   assign retired       = retired_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: per-cycle scoreboard against a behavioural model
// plus directed checks of the phase sequences, halt/resume, counter wrap and mid-STORE reset.
module tb_step_sequencer;

   localparam int unsigned CW  = 4;
   localparam logic [1:0]  CAP = 2'h0;
   localparam logic [1:0]  FET = 2'h1;
   localparam logic [1:0]  LD  = 2'h2;
   localparam logic [1:0]  ST  = 2'h3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          load_needed = 1'b0;
   logic          store_needed = 1'b0;
   logic          read_ready = 1'b0;
   logic          write_ready = 1'b0;
   logic          halt_request = 1'b0;
   logic          resume = 1'b0;
   logic [1:0]    step;
   logic          read_request;
   logic          write_request;
   logic          halted;
   logic [CW-1:0] retired;

   step_sequencer #(
      .COUNT_WIDTH (CW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .load_needed   (load_needed),
      .store_needed  (store_needed),
      .read_ready    (read_ready),
      .write_ready   (write_ready),
      .halt_request  (halt_request),
      .resume        (resume),
      .step          (step),
      .read_request  (read_request),
      .write_request (write_request),
      .halted        (halted),
      .retired       (retired)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]    step;
      logic          rreq;
      logic          wreq;
      logic          halted;
      logic [CW-1:0] retired;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   logic [1:0]    m_step   = FET;
   logic          m_halted = 1'b0;
   logic          m_sf     = 1'b0;
   logic [CW-1:0] m_ret    = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic compare(input exp_t e);
      check_eq("sb_step", {30'd0, step}, {30'd0, e.step});
      check_eq("sb_read_request", {31'd0, read_request}, {31'd0, e.rreq});
      check_eq("sb_write_request", {31'd0, write_request}, {31'd0, e.wreq});
      check_eq("sb_halted", {31'd0, halted}, {31'd0, e.halted});
      check_eq("sb_retired", 32'(retired), 32'(e.retired));
   endtask

   always @(negedge clock) begin
      if (sb.size() != 0) begin
         compare(sb.pop_front());
      end
   end

   // One clock: advance the model on the inputs held across the edge, queue its outputs.
   task automatic tick();
      exp_t e;
      @(posedge clock);
      if (!reset) begin
         m_step   = FET;
         m_halted = 1'b0;
         m_sf     = 1'b0;
         m_ret    = '0;
      end else if (m_halted) begin
         if (resume) m_halted = 1'b0;
      end else begin
         case (m_step)
            FET: if (read_ready) begin
               m_sf   = store_needed;
               m_step = load_needed ? LD : (store_needed ? ST : CAP);
            end
            LD: if (read_ready) m_step = m_sf ? ST : CAP;
            ST: if (write_ready) m_step = CAP;
            default: begin
               m_ret  = m_ret + 1'b1;
               m_step = FET;
               if (halt_request) m_halted = 1'b1;
            end
         endcase
      end
      e.step    = m_step;
      e.rreq    = !m_halted && ((m_step == FET) || (m_step == LD));
      e.wreq    = !m_halted && (m_step == ST);
      e.halted  = m_halted;
      e.retired = m_ret;
      sb.push_back(e);
      #1;
   endtask

   initial begin
      logic [1:0] exp_seq[$];
      logic       saw_write;

      // Reset and minimal instructions
      tick();
      tick();
      check_eq("rst_step", {30'd0, step}, {30'd0, FET});
      check_eq("rst_retired", 32'(retired), 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      reset      = 1'b1;
      read_ready = 1'b1;
      check_eq("first_read_request", {31'd0, read_request}, 32'd1);
      saw_write = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check_eq("min_step", {30'd0, step}, (i % 2 == 1) ? 32'(CAP) : 32'(FET));
         if (write_request) saw_write = 1'b1;
      end
      check_eq("min_retired", 32'(retired), 32'd5);
      check_eq("min_no_write", {31'd0, saw_write}, 32'd0);

      // Full path with waits; store_needed drops in LOAD to prove it was latched
      load_needed  = 1'b1;
      store_needed = 1'b1;
      for (int i = 0; i < 4; i++) exp_seq.push_back(FET);
      for (int i = 0; i < 3; i++) exp_seq.push_back(LD);
      for (int i = 0; i < 5; i++) exp_seq.push_back(ST);
      exp_seq.push_back(CAP);
      for (int i = 0; i < 13; i++) begin
         check_eq("full_step", {30'd0, step}, {30'd0, exp_seq[i]});
         read_ready  = (i == 3) || (i == 6);
         write_ready = (i == 11);
         if (i == 4) store_needed = 1'b0;
         tick();
      end
      check_eq("full_retired", 32'(retired), 32'd6);
      check_eq("full_back_to_fetch", {30'd0, step}, {30'd0, FET});

      // Halt requested during STORE and held
      load_needed  = 1'b0;
      store_needed = 1'b1;
      read_ready   = 1'b1;
      write_ready  = 1'b0;
      tick();
      check_eq("halt_in_store", {30'd0, step}, {30'd0, ST});
      halt_request = 1'b1;
      tick();
      tick();
      write_ready = 1'b1;
      tick();
      check_eq("halt_capture", {30'd0, step}, {30'd0, CAP});
      tick();
      check_eq("halt_halted", {31'd0, halted}, 32'd1);
      check_eq("halt_step", {30'd0, step}, {30'd0, FET});
      check_eq("halt_no_read", {31'd0, read_request}, 32'd0);
      check_eq("halt_no_write", {31'd0, write_request}, 32'd0);
      tick();
      tick();
      check_eq("halt_stays", {31'd0, halted}, 32'd1);
      halt_request = 1'b0;
      resume       = 1'b1;
      write_ready  = 1'b0;
      tick();
      resume = 1'b0;
      check_eq("resume_run", {31'd0, halted}, 32'd0);
      check_eq("resume_read", {31'd0, read_request}, 32'd1);
      check_eq("resume_step", {30'd0, step}, {30'd0, FET});

      // Simultaneous halt and resume: halt wins in CAPTURE, resume wins in HALTED
      store_needed = 1'b0;
      tick();
      check_eq("sim_capture", {30'd0, step}, {30'd0, CAP});
      halt_request = 1'b1;
      resume       = 1'b1;
      tick();
      check_eq("sim_halt_wins", {31'd0, halted}, 32'd1);
      tick();
      check_eq("sim_resume_wins", {31'd0, halted}, 32'd0);
      check_eq("sim_resume_step", {30'd0, step}, {30'd0, FET});
      halt_request = 1'b0;
      resume       = 1'b0;

      // Counter wrap at four bits
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         tick();
         check_eq("wrap_retired", 32'(retired), 32'((k + 1) % 16));
      end

      // Reset while a write is outstanding
      store_needed = 1'b1;
      tick();
      check_eq("mid_store_wreq", {31'd0, write_request}, 32'd1);
      reset = 1'b0;
      tick();
      check_eq("mid_rst_wreq", {31'd0, write_request}, 32'd0);
      check_eq("mid_rst_step", {30'd0, step}, {30'd0, FET});
      check_eq("mid_rst_retired", 32'(retired), 32'd0);
      reset        = 1'b1;
      store_needed = 1'b0;
      tick();
      tick();

      @(negedge clock);
      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
